// File: rtl/pipe_hazard_unit_if.sv
// Hazard-control bundle between the pipeline datapath/control and pipe_hazard_unit.
// master = pipeline side (drives hazard sources), slave = hazard unit side.
interface pipe_hazard_unit_if #(
    parameter int NREAD = 2,
    parameter int AW    = 4
);
    logic [NREAD*AW-1:0] rd_addr;
    logic [NREAD-1:0]    rd_used;
    logic                regwrite_e;
    logic                regwrite_m;
    logic                regwrite_w;
    logic [AW-1:0]       wa_e;
    logic [AW-1:0]       wa_m;
    logic [AW-1:0]       wa_w;
    logic                memread_e;
    logic                br_taken_e;
    logic                stall_if;
    logic                stall_id;
    logic                flush_id;
    logic                flush_ex;
    logic [NREAD*2-1:0]  fwd_sel;
    logic [15:0]         stall_cnt;

    modport master (
        output rd_addr, rd_used, regwrite_e, regwrite_m, regwrite_w,
               wa_e, wa_m, wa_w, memread_e, br_taken_e,
        input  stall_if, stall_id, flush_id, flush_ex, fwd_sel, stall_cnt
    );

    modport slave (
        input  rd_addr, rd_used, regwrite_e, regwrite_m, regwrite_w,
               wa_e, wa_m, wa_w, memread_e, br_taken_e,
        output stall_if, stall_id, flush_id, flush_ex, fwd_sel, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_unit.sv
// N-read-port hazard controller for the 5-stage pipeline: data stalls, branch flush FSM,
// stall-cycle counter. Define PIPE_HAZARD_FWD_EN to enable forwarding with load-use detection.
module pipe_hazard_unit #(
    parameter int NREAD      = 2,
    parameter int AW         = 4,
    parameter int BR_PENALTY = 2
) (
    input  logic                clk,
    input  logic                reset,
    pipe_hazard_unit_if.slave   hz
);
    typedef enum logic {RUN, BRFL} state_t;

    state_t             state, state_nxt;
    logic [2:0]         cnt, cnt_nxt;
    logic [NREAD-1:0]   match_e, match_m, match_w;
    logic               data_hzd;
    logic [NREAD*2-1:0] fwd_raw;
    logic               stall_if, stall_id, flush_id, flush_ex, data_stall;
    logic [NREAD*2-1:0] fwd_sel;
    logic [15:0]        stall_cnt;

    always_comb begin
        match_e = '0;
        match_m = '0;
        match_w = '0;
        for (int i = 0; i < NREAD; i++) begin
            match_e[i] = hz.rd_used[i] & hz.regwrite_e & (hz.rd_addr[i*AW +: AW] == hz.wa_e);
            match_m[i] = hz.rd_used[i] & hz.regwrite_m & (hz.rd_addr[i*AW +: AW] == hz.wa_m);
            match_w[i] = hz.rd_used[i] & hz.regwrite_w & (hz.rd_addr[i*AW +: AW] == hz.wa_w);
        end
    end

`ifdef PIPE_HAZARD_FWD_EN
    // Only a load in EX cannot be bypassed; everything else reaches MEM/WB in time.
    assign data_hzd = (|match_e) & hz.memread_e;

    always_comb begin
        fwd_raw = '0;
        for (int i = 0; i < NREAD; i++) begin
            fwd_raw[2*i+1] = match_m[i];
            fwd_raw[2*i]   = match_w[i] & ~match_m[i];
        end
    end
`else
    assign data_hzd = |(match_e | match_m | match_w);
    assign fwd_raw  = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state is written only with non-blocking assignments.
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first in every combinational block so no latch is inferred.
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                if (hz.br_taken_e && (BR_PENALTY > 1)) begin
                    state_nxt = BRFL;
                    cnt_nxt   = 3'(BR_PENALTY - 2);
                end
            end
            BRFL: begin
                if (cnt == '0) state_nxt = RUN;
                else           cnt_nxt   = cnt - 3'd1;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        flush_id   = 1'b0;
        flush_ex   = 1'b0;
        data_stall = 1'b0;
        fwd_sel    = '0;
        if (!reset) begin
            case (state)
                RUN: begin
                    fwd_sel = fwd_raw;
                    if (hz.br_taken_e) begin
                        // The ID instruction is on the wrong path, so its hazards are moot.
                        flush_id = 1'b1;
                        flush_ex = 1'b1;
                    end else if (data_hzd) begin
                        stall_if   = 1'b1;
                        stall_id   = 1'b1;
                        flush_ex   = 1'b1;
                        data_stall = 1'b1;
                    end
                end
                BRFL:    flush_id = 1'b1;
                default: flush_id = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt <= '0;
        else if (data_stall && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end

    assign hz.stall_if  = stall_if;
    assign hz.stall_id  = stall_id;
    assign hz.flush_id  = flush_id;
    assign hz.flush_ex  = flush_ex;
    assign hz.fwd_sel   = fwd_sel;
    assign hz.stall_cnt = stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit (NREAD=2, AW=4, BR_PENALTY=3); expectations follow
// whether PIPE_HAZARD_FWD_EN is defined for the build.
module tb_pipe_hazard_unit;
`ifdef PIPE_HAZARD_FWD_EN
    localparam bit F = 1'b1;
`else
    localparam bit F = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;

    pipe_hazard_unit_if #(.NREAD(2), .AW(4)) hz ();

    pipe_hazard_unit #(.NREAD(2), .AW(4), .BR_PENALTY(3)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic si, input logic sd,
                       input logic fi, input logic fe, input logic [3:0] fwd);
        check({tag, ".stall_if"}, 32'(hz.stall_if), 32'(si));
        check({tag, ".stall_id"}, 32'(hz.stall_id), 32'(sd));
        check({tag, ".flush_id"}, 32'(hz.flush_id), 32'(fi));
        check({tag, ".flush_ex"}, 32'(hz.flush_ex), 32'(fe));
        check({tag, ".fwd_sel"},  32'(hz.fwd_sel),  32'(fwd));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        hz.rd_addr    = '0;
        hz.rd_used    = '0;
        hz.regwrite_e = 1'b0;
        hz.regwrite_m = 1'b0;
        hz.regwrite_w = 1'b0;
        hz.wa_e       = '0;
        hz.wa_m       = '0;
        hz.wa_w       = '0;
        hz.memread_e  = 1'b0;
        hz.br_taken_e = 1'b0;
    endtask

    initial begin
        // Reset with hazards and a branch present: everything must stay quiet.
        reset = 1'b1;
        set_idle();
        hz.rd_addr    = {4'd5, 4'd7};
        hz.rd_used    = 2'b11;
        hz.regwrite_e = 1'b1;
        hz.memread_e  = 1'b1;
        hz.wa_e       = 4'd7;
        hz.br_taken_e = 1'b1;
        #3;
        chk("rst", 0, 0, 0, 0, 4'b0000);
        check("rst.stall_cnt", 32'(hz.stall_cnt), 32'd0);
        tick();
        chk("rst_edge", 0, 0, 0, 0, 4'b0000);
        set_idle();
        reset = 1'b0;
        tick();

        // Writer of r3 walks EX -> MEM -> WB, read on port 0.
        hz.rd_addr    = {4'd0, 4'd3};
        hz.rd_used    = 2'b01;
        hz.regwrite_e = 1'b1;
        hz.wa_e       = 4'd3;
        #1 chk("t1_e", !F, !F, 0, !F, 4'b0000);
        tick();
        hz.regwrite_e = 1'b0;
        hz.regwrite_m = 1'b1;
        hz.wa_m       = 4'd3;
        #1 chk("t1_m", !F, !F, 0, !F, F ? 4'b0010 : 4'b0000);
        tick();
        hz.regwrite_m = 1'b0;
        hz.regwrite_w = 1'b1;
        hz.wa_w       = 4'd3;
        #1 chk("t1_w", !F, !F, 0, !F, F ? 4'b0001 : 4'b0000);
        tick();
        hz.regwrite_w = 1'b0;
        #1 chk("t1_done", 0, 0, 0, 0, 4'b0000);
        exp_cnt = F ? 0 : 3;
        check("t1.stall_cnt", 32'(hz.stall_cnt), 32'(exp_cnt));

        // Matching load in EX, but the port is not used.
        hz.rd_used    = 2'b00;
        hz.regwrite_e = 1'b1;
        hz.memread_e  = 1'b1;
        hz.wa_e       = 4'd3;
        #1 chk("t2_unused", 0, 0, 0, 0, 4'b0000);
        tick();
        set_idle();

        // Port 1 reads r5 with matches in MEM and WB, then WB only.
        hz.rd_addr    = {4'd5, 4'd0};
        hz.rd_used    = 2'b10;
        hz.regwrite_m = 1'b1;
        hz.wa_m       = 4'd5;
        hz.regwrite_w = 1'b1;
        hz.wa_w       = 4'd5;
        #1 chk("t3_mw", !F, !F, 0, !F, F ? 4'b1000 : 4'b0000);
        exp_cnt += F ? 0 : 1;
        tick();
        hz.regwrite_m = 1'b0;
        #1 chk("t3_w", !F, !F, 0, !F, F ? 4'b0100 : 4'b0000);
        exp_cnt += F ? 0 : 1;
        tick();
        set_idle();
        #1 check("t3.stall_cnt", 32'(hz.stall_cnt), 32'(exp_cnt));

        // Load-use on port 0: stall while the load is in EX, then forward from MEM.
        hz.rd_addr    = {4'd0, 4'd7};
        hz.rd_used    = 2'b01;
        hz.regwrite_e = 1'b1;
        hz.memread_e  = 1'b1;
        hz.wa_e       = 4'd7;
        #1 chk("t4_load", 1, 1, 0, 1, 4'b0000);
        exp_cnt += 1;
        tick();
        hz.regwrite_e = 1'b0;
        hz.memread_e  = 1'b0;
        hz.regwrite_m = 1'b1;
        hz.wa_m       = 4'd7;
        #1 chk("t4_mem", !F, !F, 0, !F, F ? 4'b0010 : 4'b0000);
        exp_cnt += F ? 0 : 1;
        tick();
        set_idle();
        #1 check("t4.stall_cnt", 32'(hz.stall_cnt), 32'(exp_cnt));

        // Taken branch alongside a load-use hazard: 3-cycle flush_id, no stalls.
        hz.rd_addr    = {4'd5, 4'd7};
        hz.rd_used    = 2'b01;
        hz.regwrite_e = 1'b1;
        hz.memread_e  = 1'b1;
        hz.wa_e       = 4'd7;
        hz.br_taken_e = 1'b1;
        #1 chk("t5_br1", 0, 0, 1, 1, 4'b0000);
        tick();
        hz.rd_used    = 2'b11;
        hz.regwrite_m = 1'b1;
        hz.wa_m       = 4'd5;
        #1 chk("t5_br2", 0, 0, 1, 0, 4'b0000);
        tick();
        hz.br_taken_e = 1'b0;
        #1 chk("t5_br3", 0, 0, 1, 0, 4'b0000);
        tick();
        set_idle();
        #1 chk("t5_run", 0, 0, 0, 0, 4'b0000);
        check("t5.stall_cnt", 32'(hz.stall_cnt), 32'(exp_cnt));

        // Reset in the second BRFL cycle aborts the penalty at once.
        hz.br_taken_e = 1'b1;
        #1 chk("t6_br1", 0, 0, 1, 1, 4'b0000);
        tick();
        hz.br_taken_e = 1'b0;
        #1 check("t6_brfl1.flush_id", 32'(hz.flush_id), 32'd1);
        tick();
        check("t6_brfl2.flush_id", 32'(hz.flush_id), 32'd1);
        reset = 1'b1;
        #1 check("t6_rst.flush_id", 32'(hz.flush_id), 32'd0);
        #1 reset = 1'b0;
        #1 chk("t6_rel", 0, 0, 0, 0, 4'b0000);
        tick();
        chk("t6_run", 0, 0, 0, 0, 4'b0000);
        check("t6.stall_cnt", 32'(hz.stall_cnt), 32'd0);

        // Continuous load-use hazard drives the counter into saturation.
        hz.rd_addr    = {4'd0, 4'd7};
        hz.rd_used    = 2'b01;
        hz.regwrite_e = 1'b1;
        hz.memread_e  = 1'b1;
        hz.wa_e       = 4'd7;
        for (int i = 0; i < 65534; i++) tick();
        check("t7_fffe.stall_cnt", 32'(hz.stall_cnt), 32'h0000_FFFE);
        tick();
        check("t7_ffff.stall_cnt", 32'(hz.stall_cnt), 32'h0000_FFFF);
        for (int i = 0; i < 5; i++) tick();
        check("t7_hold.stall_cnt", 32'(hz.stall_cnt), 32'h0000_FFFF);
        chk("t7_stall", 1, 1, 0, 1, 4'b0000);
        set_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard controller for the 5-stage ARM pipeline (IF/ID/EX/MEM/WB), sitting beside the pipelined control unit and driving pipeline-register enables/flushes and operand-forwarding muxes. It generalises the fixed two-read-port stall logic to N read ports. It adds optional forwarding with load-use detection and an internal branch-penalty FSM that replaces the external stall-count loop. A saturating stall-cycle counter exposes hazard cost for performance tests.

## Interface
- NREAD, 2: register read ports checked in ID (2..4)
- AW, 4: register address width
- BR_PENALTY, 2: cycles flush_id is held after a taken branch (1..7)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- rd_addr  in  NREAD*AW  ID-stage read addresses, port i at [i*AW +: AW]
- rd_used  in  NREAD  port i actually read by ID instruction
- regwrite_e, regwrite_m, regwrite_w  in  1 each  writer valid in EX/MEM/WB
- wa_e, wa_m, wa_w  in  AW each  write address in EX/MEM/WB
- memread_e  in  1  EX instruction is a load
- br_taken_e  in  1  taken branch resolved in EX
- stall_if, stall_id  out  1  hold PC / IF-ID register
- flush_id, flush_ex  out  1  bubble IF-ID / ID-EX register
- fwd_sel  out  NREAD*2  per port: 00 regfile, 10 MEM result, 01 WB result
- stall_cnt  out  16  saturating count of data-stall cycles

## Operation
- match_X[i] = rd_used[i] & regwrite_X & (rd_addr[i] == wa_X), X in {e,m,w}.
- FSM states: RUN, BRFL. Reset -> RUN, internal cnt = 0, stall_cnt = 0.
- RUN, br_taken_e=1: flush_id=1, flush_ex=1, stall_if=stall_id=0; if BR_PENALTY>1, go BRFL with cnt=BR_PENALTY-2, else stay RUN. Branch overrides any data hazard in the same cycle (ID instruction is wrong-path).
- BRFL: flush_id=1, all stalls 0, fwd_sel=0, data hazards ignored, br_taken_e ignored; cnt==0 -> RUN else cnt-1.
- RUN, no branch: data_hzd per Configuration; data_hzd -> stall_if=stall_id=flush_ex=1, flush_id=0. Stall re-evaluated every cycle, no internal latching.
- stall_cnt increments by 1 each cycle stall_id=1 due to data hazard (not branch); holds at 16'hFFFF.
- Forwarding priority per port: MEM over WB; a port matching only EX gets fwd_sel=00 (covered by stall).
- Port with rd_used=0 never stalls, fwd_sel=00.

## Timing
- All stall/flush/fwd_sel outputs combinational from current inputs and state, valid in the same cycle.
- State, cnt, and stall_cnt update on posedge clk.
- Branch penalty: flush_id high for exactly BR_PENALTY consecutive cycles starting in the br_taken_e cycle; flush_ex high only in that first cycle.
- While reset=1: all outputs 0, fwd_sel=0, stall_cnt=0, state RUN. Reset mid-BRFL aborts the penalty immediately.
- stall_cnt is visible the cycle after the counted stall.

## Configuration
- PIPE_HAZARD_FWD_EN defined: data_hzd = OR over ports of (match_e[i] & memread_e) (load-use, 1-cycle stall). MEM/WB matches are forwarded via fwd_sel, and non-load EX matches do not stall because the value reaches MEM next cycle.
- Undefined: data_hzd = OR over ports of (match_e|match_m|match_w). fwd_sel tied to 0. Full stall until the writer leaves WB.

## Test plan
- No forwarding, rd_addr port0=3, rd_used=01, regwrite_e=1, wa_e=3, writer advances each cycle -> stall_if/stall_id/flush_ex high 3 cycles, then low; stall_cnt=3.
- FWD_EN, port1=5 used, regwrite_m=1, wa_m=5, regwrite_w=1, wa_w=5 -> no stall, fwd_sel[3:2]=10; drop M match -> 01.
- FWD_EN, memread_e=1, wa_e=7, port0=7 -> single stall cycle, then fwd_sel[1:0]=10 with no stall.
- BR_PENALTY=3, br_taken_e=1 together with a data hazard -> flush_id high 3 cycles, flush_ex only cycle 1, no stall, stall_cnt unchanged.
- Assert reset in the 2nd BRFL cycle -> flush_id=0 immediately. After release, state RUN: br_taken_e=0 yields flush_id=0.
- Force continuous data hazard 70000 cycles -> stall_cnt saturates at 16'hFFFF.
